// File: rtl/dma_hold_arbiter_if.sv
// Bus-hold handshake bundle between the DMA hold arbiter, the coprocessor HOLD
// lines, the CPU memory stage and the external-bus mux.
interface dma_hold_arbiter_if #(
  parameter int N_REQ = 4
) ();
  logic [N_REQ-1:0] hold_req;
  logic [N_REQ-1:0] hold_ack;
  logic             cpu_mem_busy;
  logic             cpu_stall;
  logic             bus_owned;
  logic [2:0]       bus_sel;
  logic             timeout_irq;
  logic [2:0]       timeout_id;
  logic             timeout_clr;

  // Arbiter side
  modport master (
    input  hold_req, cpu_mem_busy, timeout_clr,
    output hold_ack, cpu_stall, bus_owned, bus_sel, timeout_irq, timeout_id
  );

  // Requester / CPU / mux side
  modport slave (
    output hold_req, cpu_mem_busy, timeout_clr,
    input  hold_ack, cpu_stall, bus_owned, bus_sel, timeout_irq, timeout_id
  );
endinterface

// File: rtl/dma_hold_arbiter.sv
// Round-robin, non-preemptive HOLD/HOLD_ACK arbiter for the shared external bus.
// Stalls the CPU, drains its in-flight access, then grants; flags long tenures.
module dma_hold_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic                clk,
  input  logic                rst,
  dma_hold_arbiter_if.master  bus
);

  typedef enum logic [1:0] {IDLE, STALL, GRANT, RELEASE} state_t;

  localparam logic [3:0]       N4     = 4'(N_REQ);
  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_M1  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [N_REQ-1:0] hold_ack_q, hold_ack_d;
  logic             cpu_stall_q, cpu_stall_d;
  logic             bus_owned_q, bus_owned_d;
  logic [2:0]       bus_sel_q, bus_sel_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_irq_q, timeout_irq_d;
  logic [2:0]       timeout_id_q, timeout_id_d;

  logic [N_REQ-1:0] rot_req;
  logic [2:0]       rot_idx [N_REQ];
  logic [N_REQ-1:0] ack_sel;
  logic             owner_req;
  logic             win_found;
  logic [2:0]       win_idx;
  logic [3:0]       sel_inc;

  // rot_req[gi] is the request of the requester gi positions after rr_ptr
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    localparam logic [3:0] OFF = 4'(gi);
    logic [3:0] sum;
    assign sum         = {1'b0, rr_ptr_q} + OFF;
    assign rot_idx[gi] = (sum >= N4) ? 3'(sum - N4) : sum[2:0];

    always_comb begin
      rot_req[gi] = 1'b0;
      for (int j = 0; j < N_REQ; j++) begin
        if (rot_idx[gi] == 3'(j)) rot_req[gi] = bus.hold_req[j];
      end
    end

    assign ack_sel[gi] = (bus_sel_q == 3'(gi));
  end

  // Lowest rotated offset wins
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot_req[i]) begin
        win_found = 1'b1;
        win_idx   = rot_idx[i];
      end
    end
  end

  always_comb begin
    owner_req = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (bus_sel_q == 3'(i)) owner_req = bus.hold_req[i];
    end
  end

  assign sel_inc = {1'b0, bus_sel_q} + 4'd1;

  always_comb begin
    state_d       = state_q;
    hold_ack_d    = hold_ack_q;
    cpu_stall_d   = cpu_stall_q;
    bus_owned_d   = bus_owned_q;
    bus_sel_d     = bus_sel_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    timeout_irq_d = timeout_irq_q;
    timeout_id_d  = timeout_id_q;

    // Clear first so a same-cycle set below overrides it
    if (bus.timeout_clr) timeout_irq_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d     = STALL;
          bus_sel_d   = win_idx;
          cpu_stall_d = 1'b1;
        end
      end
      STALL: begin
        if (!owner_req) begin
          state_d     = RELEASE;
          cpu_stall_d = 1'b0;
        end else if (!bus.cpu_mem_busy) begin
          state_d     = GRANT;
          hold_ack_d  = ack_sel;
          bus_owned_d = 1'b1;
          cnt_d       = '0;
        end
      end
      GRANT: begin
        // Ack drops on the same edge that sees the request fall
        if (!owner_req) begin
          state_d     = RELEASE;
          hold_ack_d  = '0;
          bus_owned_d = 1'b0;
          cpu_stall_d = 1'b0;
        end else begin
          if (cnt_q != TO_MAX) cnt_d = cnt_q + ONE;
          if (cnt_q == TO_M1) begin
            timeout_irq_d = 1'b1;
            timeout_id_d  = bus_sel_q;
          end
        end
      end
      RELEASE: begin
        hold_ack_d  = '0;
        bus_owned_d = 1'b0;
        cpu_stall_d = 1'b0;
        rr_ptr_d    = (sel_inc == N4) ? 3'd0 : sel_inc[2:0];
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      hold_ack_q    <= '0;
      cpu_stall_q   <= 1'b0;
      bus_owned_q   <= 1'b0;
      bus_sel_q     <= 3'd0;
      rr_ptr_q      <= 3'd0;
      cnt_q         <= '0;
      timeout_irq_q <= 1'b0;
      timeout_id_q  <= 3'd0;
    end else begin
      state_q       <= state_d;
      hold_ack_q    <= hold_ack_d;
      cpu_stall_q   <= cpu_stall_d;
      bus_owned_q   <= bus_owned_d;
      bus_sel_q     <= bus_sel_d;
      rr_ptr_q      <= rr_ptr_d;
      cnt_q         <= cnt_d;
      timeout_irq_q <= timeout_irq_d;
      timeout_id_q  <= timeout_id_d;
    end
  end

  assign bus.hold_ack    = hold_ack_q;
  assign bus.cpu_stall   = cpu_stall_q;
  assign bus.bus_owned   = bus_owned_q;
  assign bus.bus_sel     = bus_sel_q;
  assign bus.timeout_irq = timeout_irq_q;
  assign bus.timeout_id  = timeout_id_q;

endmodule

// File: tb/tb_dma_hold_arbiter.sv
// Directed bench for dma_hold_arbiter: latency, CPU drain, round-robin order,
// withdraw-in-stall, tenure timeout with clear priority, and reset mid-grant.
module tb_dma_hold_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  dma_hold_arbiter_if #(.N_REQ(4)) bif ();

  dma_hold_arbiter #(.N_REQ(4), .TIMEOUT(16), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1ns after the edge, plus invariants every cycle
  task automatic tick();
    @(posedge clk);
    #1;
    chk("inv_onehot", 32'($onehot0(bif.hold_ack)), 32'd1);
    chk("inv_ack_implies", 32'((bif.hold_ack == 4'b0) || (bif.cpu_stall && bif.bus_owned)), 32'd1);
  endtask

  task automatic show(input string what);
    $display("[%0t] %s req=%b busy=%b ack=%b stall=%b owned=%b sel=%0d irq=%b id=%0d",
             $time, what, bif.hold_req, bif.cpu_mem_busy, bif.hold_ack, bif.cpu_stall,
             bif.bus_owned, bif.bus_sel, bif.timeout_irq, bif.timeout_id);
  endtask

  initial begin
    logic [3:0] onehot;
    rst              = 1'b1;
    bif.hold_req     = 4'b0000;
    bif.cpu_mem_busy = 1'b0;
    bif.timeout_clr  = 1'b0;
    tick();
    tick();
    show("reset");
    chk("rst_ack",   32'(bif.hold_ack),    32'h0);
    chk("rst_stall", 32'(bif.cpu_stall),   32'h0);
    chk("rst_owned", 32'(bif.bus_owned),   32'h0);
    chk("rst_sel",   32'(bif.bus_sel),     32'h0);
    chk("rst_irq",   32'(bif.timeout_irq), 32'h0);
    chk("rst_id",    32'(bif.timeout_id),  32'h0);
    chk("rst_rr",    32'(dut.rr_ptr_q),    32'h0);
    rst = 1'b0;
    tick();

    // Single requester: stall at +1, ack at +2, ack/stall drop 1 edge after req falls
    bif.hold_req = 4'b0001;
    tick();
    show("single +1");
    chk("single_stall1", 32'(bif.cpu_stall), 32'h1);
    chk("single_ack1",   32'(bif.hold_ack),  32'h0);
    tick();
    show("single +2");
    chk("single_ack2",   32'(bif.hold_ack),  32'h1);
    chk("single_owned2", 32'(bif.bus_owned), 32'h1);
    tick();
    bif.hold_req = 4'b0000;
    tick();
    show("single drop");
    chk("single_ackdrop",   32'(bif.hold_ack),  32'h0);
    chk("single_stalldrop", 32'(bif.cpu_stall), 32'h0);
    tick();
    chk("single_rr", 32'(dut.rr_ptr_q), 32'h1);

    // CPU drain: busy for 5 cycles holds off the grant
    bif.cpu_mem_busy = 1'b1;
    bif.hold_req     = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("drain_stall", 32'(bif.cpu_stall), 32'h1);
      chk("drain_noack", 32'(bif.hold_ack),  32'h0);
    end
    show("drain busy");
    bif.cpu_mem_busy = 1'b0;
    tick();
    show("drain grant");
    chk("drain_ack", 32'(bif.hold_ack), 32'h2);
    chk("drain_sel", 32'(bif.bus_sel),  32'h1);
    bif.hold_req = 4'b0000;
    tick();
    tick();

    // Round-robin from rr_ptr=0 with all four requesting
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bif.hold_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      onehot = 4'b0001 << (k % 4);
      tick();
      chk("rr_stall", 32'(bif.cpu_stall), 32'h1);
      tick();
      show("rr grant");
      chk("rr_ack", 32'(bif.hold_ack), 32'(onehot));
      chk("rr_sel", 32'(bif.bus_sel),  32'(k % 4));
      tick();
      tick();
      bif.hold_req = 4'b1111 & ~onehot;
      tick();
      chk("rr_rel_ack",   32'(bif.hold_ack),  32'h0);
      chk("rr_rel_stall", 32'(bif.cpu_stall), 32'h0);
      bif.hold_req = 4'b1111;
      tick();
      chk("rr_idle_stall", 32'(bif.cpu_stall), 32'h0);
    end
    bif.hold_req = 4'b0000;
    tick();
    tick();
    chk("rr_ptr_after", 32'(dut.rr_ptr_q), 32'h1);

    // Withdraw while stalled behind a busy CPU
    bif.cpu_mem_busy = 1'b1;
    bif.hold_req     = 4'b0100;
    tick();
    chk("wd_stall", 32'(bif.cpu_stall), 32'h1);
    chk("wd_sel",   32'(bif.bus_sel),   32'h2);
    tick();
    bif.hold_req = 4'b0000;
    tick();
    show("withdraw");
    chk("wd_noack",  32'(bif.hold_ack),  32'h0);
    chk("wd_unstall", 32'(bif.cpu_stall), 32'h0);
    tick();
    chk("wd_rr", 32'(dut.rr_ptr_q), 32'h3);
    bif.cpu_mem_busy = 1'b0;

    // Timeout after 16 granted cycles, no preemption
    bif.hold_req = 4'b1000;
    tick();
    tick();
    chk("to_ack", 32'(bif.hold_ack), 32'h8);
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk("to_irq_early", 32'(bif.timeout_irq), 32'h0);
    end
    tick();
    show("timeout");
    chk("to_irq", 32'(bif.timeout_irq), 32'h1);
    chk("to_id",  32'(bif.timeout_id),  32'h3);
    for (int k = 0; k < 23; k++) begin
      tick();
      chk("to_ack_held", 32'(bif.hold_ack),    32'h8);
      chk("to_irq_held", 32'(bif.timeout_irq), 32'h1);
    end
    bif.timeout_clr = 1'b1;
    tick();
    bif.timeout_clr = 1'b0;
    chk("to_clr", 32'(bif.timeout_irq), 32'h0);
    bif.hold_req = 4'b0000;
    tick();
    tick();

    // Second tenure: clear in the same cycle as a new timeout, set wins
    bif.hold_req = 4'b1000;
    tick();
    tick();
    chk("to2_ack", 32'(bif.hold_ack), 32'h8);
    for (int k = 1; k <= 15; k++) tick();
    chk("to2_irq_early", 32'(bif.timeout_irq), 32'h0);
    bif.timeout_clr = 1'b1;
    tick();
    bif.timeout_clr = 1'b0;
    show("set vs clr");
    chk("to2_setwins", 32'(bif.timeout_irq), 32'h1);

    // Reset mid-grant, then regrant through a fresh IDLE->STALL
    rst = 1'b1;
    tick();
    rst = 1'b0;
    show("reset mid-grant");
    chk("mr_ack",   32'(bif.hold_ack),  32'h0);
    chk("mr_stall", 32'(bif.cpu_stall), 32'h0);
    chk("mr_rr",    32'(dut.rr_ptr_q),  32'h0);
    tick();
    chk("mr_restall", 32'(bif.cpu_stall), 32'h1);
    chk("mr_noack",   32'(bif.hold_ack),  32'h0);
    tick();
    show("regrant");
    chk("mr_regrant", 32'(bif.hold_ack), 32'h8);
    bif.hold_req = 4'b0000;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
